// File: rtl/store_buffer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_buffer_if : MEM allocate, ROB commit, memory write and load-check bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int SB_SIZE = 4,
  parameter int IDX_W   = $clog2(SB_SIZE)
);
  logic             alloc_valid_i;
  logic [31:0]      alloc_addr_i;
  logic [31:0]      alloc_data_i;
  logic [3:0]       alloc_be_i;
  logic             alloc_ready_o;
  logic [IDX_W-1:0] alloc_idx_o;
  logic             commit_valid_i;
  logic [IDX_W-1:0] commit_idx_i;
  logic             flush_i;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic [3:0]       mem_be_o;
  logic             mem_gnt_i;
  logic [31:0]      ld_addr_i;
  logic [3:0]       ld_be_i;
  logic             ld_hazard_o;
  logic [IDX_W:0]   count_o;
  logic             empty_o;
  logic             full_o;

  modport master (
    output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_be_i,
    input  alloc_ready_o, alloc_idx_o,
    output commit_valid_i, commit_idx_i, flush_i,
    input  mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
    output mem_gnt_i, ld_addr_i, ld_be_i,
    input  ld_hazard_o, count_o, empty_o, full_o
  );

  modport slave (
    input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_be_i,
    output alloc_ready_o, alloc_idx_o,
    input  commit_valid_i, commit_idx_i, flush_i,
    output mem_req_o, mem_addr_o, mem_data_o, mem_be_o,
    input  mem_gnt_i, ld_addr_i, ld_be_i,
    output ld_hazard_o, count_o, empty_o, full_o
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// store_buffer_ctrl : in-order store buffer, ROB-committed drain to memory
// Revision 1.0
// ---------------------------------------------------------------------------
module store_buffer_ctrl #(
  parameter int SB_SIZE = 4,
  parameter int IDX_W   = $clog2(SB_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave sb
);
  localparam logic [0:0]       S_IDLE     = 1'b0;
  localparam logic [0:0]       S_REQ      = 1'b1;
  localparam logic [IDX_W:0]   C_FULL_CNT = (IDX_W+1)'(SB_SIZE);
  localparam logic [IDX_W:0]   C_CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  logic [SB_SIZE-1:0][29:0] addr_q;
  logic [SB_SIZE-1:0][31:0] data_q;
  logic [SB_SIZE-1:0][3:0]  be_q;
  logic [SB_SIZE-1:0]       valid_q, valid_d;
  logic [SB_SIZE-1:0]       cmtd_q, cmtd_d;
  logic [IDX_W-1:0]         head_q, head_d;
  logic [IDX_W-1:0]         cmt_q, cmt_d;
  logic [IDX_W-1:0]         tail_q, tail_d;
  logic [IDX_W:0]           count_q, count_d;
  logic [0:0]               state_q, state_d;

  logic                     w_alloc_ready;
  logic                     w_alloc_fire;
  logic                     w_commit_ok;
  logic                     w_commit_fire;
  logic                     w_gnt_fire;
  logic                     w_req;
  logic [IDX_W-1:0]         w_head_nxt;
  logic [SB_SIZE-1:0]       w_cmtd_after;
  logic [SB_SIZE-1:0]       w_discard;
  logic [SB_SIZE-1:0]       w_ld_hit;
  logic [IDX_W:0]           w_discard_cnt;
  logic                     w_unused;

  // The slot at cmt is uncommitted only if occupied and not yet committed;
  // this also covers the full-buffer case where cmt==tail.
  assign w_commit_ok   = (sb.commit_idx_i == cmt_q) && valid_q[cmt_q] && !cmtd_q[cmt_q];
  assign w_commit_fire = sb.commit_valid_i && w_commit_ok;
  assign w_alloc_ready = (count_q != C_FULL_CNT) && !sb.flush_i;
  assign w_alloc_fire  = sb.alloc_valid_i && w_alloc_ready;
  assign w_req         = (state_q == S_REQ);
  assign w_gnt_fire    = w_req && sb.mem_gnt_i;
  assign w_head_nxt    = head_q + C_IDX_ONE;
  assign w_unused      = ^{sb.alloc_addr_i[1:0], sb.ld_addr_i[1:0]};

  always_comb begin
    w_cmtd_after = cmtd_q;
    if (w_commit_fire) w_cmtd_after[cmt_q] = 1'b1;
    w_discard     = sb.flush_i ? (valid_q & ~w_cmtd_after) : '0;
    w_discard_cnt = '0;
    for (int i = 0; i < SB_SIZE; i++) begin
      w_discard_cnt = w_discard_cnt + {{IDX_W{1'b0}}, w_discard[i]};
    end

    valid_d = valid_q & ~w_discard;
    cmtd_d  = w_cmtd_after;
    if (w_gnt_fire) begin
      valid_d[head_q] = 1'b0;
      cmtd_d[head_q]  = 1'b0;
    end
    if (w_alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      cmtd_d[tail_q]  = 1'b0;
    end

    head_d = w_gnt_fire ? w_head_nxt : head_q;
    cmt_d  = w_commit_fire ? (cmt_q + C_IDX_ONE) : cmt_q;
    tail_d = sb.flush_i ? cmt_d : (w_alloc_fire ? (tail_q + C_IDX_ONE) : tail_q);

    count_d = count_q - w_discard_cnt;
    if (w_alloc_fire) count_d = count_d + C_CNT_ONE;
    if (w_gnt_fire)   count_d = count_d - C_CNT_ONE;

    // Same-cycle commits are seen, giving one-cycle commit-to-request latency.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_cmtd_after[head_q]) state_d = S_REQ;
      S_REQ:   if (sb.mem_gnt_i) state_d = w_cmtd_after[w_head_nxt] ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cmtd_q  <= '0;
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
    end else begin
      valid_q <= valid_d;
      cmtd_q  <= cmtd_d;
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Payload is qualified by valid_q and the REQ state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      addr_q[tail_q] <= sb.alloc_addr_i[31:2];
      data_q[tail_q] <= sb.alloc_data_i;
      be_q[tail_q]   <= sb.alloc_be_i;
    end
  end

  for (genvar gi = 0; gi < SB_SIZE; gi++) begin : g_ld_hit
    assign w_ld_hit[gi] = valid_q[gi]
                        && (addr_q[gi] == sb.ld_addr_i[31:2])
                        && ((be_q[gi] & sb.ld_be_i) != 4'b0000);
  end

  assign sb.alloc_ready_o = w_alloc_ready;
  assign sb.alloc_idx_o   = tail_q;
  assign sb.mem_req_o     = w_req;
  assign sb.mem_addr_o    = w_req ? {addr_q[head_q], 2'b00} : 32'h0;
  assign sb.mem_data_o    = w_req ? data_q[head_q] : 32'h0;
  assign sb.mem_be_o      = w_req ? be_q[head_q] : 4'h0;
  assign sb.ld_hazard_o   = |w_ld_hit;
  assign sb.count_o       = count_q;
  assign sb.empty_o       = (count_q == '0);
  assign sb.full_o        = (count_q == C_FULL_CNT);

  always @(posedge clk) begin
    if (rst_n && sb.commit_valid_i) begin
      assert (w_commit_ok)
        else $warning("store_buffer_ctrl: out-of-order commit idx %0d ignored (expected %0d)",
                      sb.commit_idx_i, cmt_q);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_store_buffer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_store_buffer_ctrl : directed + random bench with a queue-based store model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_store_buffer_ctrl;
  localparam int SB = 4;
  localparam int IW = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          cm;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.SB_SIZE(SB), .IDX_W(IW)) sb ();
  store_buffer_ctrl #(.SB_SIZE(SB), .IDX_W(IW)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));

  // Model: program-ordered queue of buffered stores; the first ncmt are committed.
  st_t q[$];
  int  head_idx, ncmt, writes, dut_writes, tests, fails, issued, w0;
  bit  exp_req, bad_done;

  always @(posedge clk) if (rst_n && sb.mem_req_o && sb.mem_gnt_i) dut_writes <= dut_writes + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic idle_in();
    sb.alloc_valid_i = 1'b0; sb.alloc_addr_i = '0; sb.alloc_data_i = '0; sb.alloc_be_i = '0;
    sb.commit_valid_i = 1'b0; sb.commit_idx_i = '0; sb.flush_i = 1'b0; sb.mem_gnt_i = 1'b0;
    sb.ld_addr_i = 32'hFFFF_FFF0; sb.ld_be_i = 4'h0;
  endtask

  task automatic model_reset();
    q.delete(); head_idx = 0; ncmt = 0; exp_req = 1'b0;
  endtask

  task automatic check_outputs();
    bit hz;
    hz = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == sb.ld_addr_i[31:2] && (q[i].be & sb.ld_be_i) != 4'h0) hz = 1'b1;
    chk("count", 32'(sb.count_o), 32'(q.size()));
    chk("empty", 32'(sb.empty_o), 32'(q.size() == 0));
    chk("full", 32'(sb.full_o), 32'(q.size() == SB));
    chk("alloc_ready", 32'(sb.alloc_ready_o), 32'(q.size() < SB && !sb.flush_i));
    chk("alloc_idx", 32'(sb.alloc_idx_o), 32'((head_idx + q.size()) % SB));
    chk("ld_hazard", 32'(sb.ld_hazard_o), 32'(hz));
    chk("mem_req", 32'(sb.mem_req_o), 32'(exp_req));
    chk("mem_addr", sb.mem_addr_o, exp_req ? {q[0].addr[31:2], 2'b00} : 32'h0);
    chk("mem_data", sb.mem_data_o, exp_req ? q[0].data : 32'h0);
    chk("mem_be", 32'(sb.mem_be_o), exp_req ? 32'(q[0].be) : 32'h0);
  endtask

  // Check this cycle's outputs, apply the cycle's effects to the model, advance.
  task automatic step();
    bit  af;
    st_t e;
    #1;
    check_outputs();
    af = sb.alloc_valid_i && q.size() < SB && !sb.flush_i;
    if (sb.commit_valid_i && ncmt < q.size() && int'(sb.commit_idx_i) == (head_idx + ncmt) % SB) begin
      e = q[ncmt]; e.cm = 1'b1; q[ncmt] = e; ncmt++;
    end
    if (exp_req && sb.mem_gnt_i) begin
      void'(q.pop_front()); head_idx = (head_idx + 1) % SB; ncmt--; writes++;
    end
    if (sb.flush_i) while (q.size() > ncmt) void'(q.pop_back());
    if (af) begin
      e.addr = sb.alloc_addr_i; e.data = sb.alloc_data_i; e.be = sb.alloc_be_i; e.cm = 1'b0;
      q.push_back(e);
    end
    exp_req = (q.size() > 0) && q[0].cm;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    sb.alloc_valid_i = 1'b1; sb.alloc_addr_i = a; sb.alloc_data_i = d; sb.alloc_be_i = be;
  endtask

  task automatic commit_next();
    sb.commit_valid_i = 1'b1; sb.commit_idx_i = IW'((head_idx + ncmt) % SB);
  endtask

  task automatic drain_all(input string tag);
    for (int c = 0; c < 100 && q.size() != 0; c++) begin
      idle_in(); sb.mem_gnt_i = 1'b1;
      if (ncmt < q.size()) commit_next();
      step();
    end
    idle_in();
    #1 chk(tag, 32'(sb.empty_o), 32'd1);
  endtask

  task automatic do_reset();
    idle_in(); rst_n = 1'b0; model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; writes = 0; dut_writes = 0; bad_done = 1'b0;
    do_reset();
    step();

    // Fill: indices 0..3 handed out, then full
    for (int i = 0; i < 4; i++) begin
      idle_in(); alloc(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF); step();
    end
    idle_in();
    #1 chk("fill.full", 32'(sb.full_o), 32'd1);
    chk("fill.ready", 32'(sb.alloc_ready_o), 32'd0);
    chk("fill.req", 32'(sb.mem_req_o), 32'd0);
    step();

    // Commit 0 and 1 with grant held: 0x100 then 0x104 on consecutive cycles
    sb.mem_gnt_i = 1'b1; sb.commit_valid_i = 1'b1; sb.commit_idx_i = 2'd0;
    #1 chk("cmt.req_lat0", 32'(sb.mem_req_o), 32'd0);
    step();
    sb.commit_idx_i = 2'd1;
    #1 chk("cmt.addr0", sb.mem_addr_o, 32'h100);
    step();
    sb.commit_valid_i = 1'b0;
    #1 chk("cmt.addr1", sb.mem_addr_o, 32'h104);
    step();
    #1 chk("cmt.count2", 32'(sb.count_o), 32'd2);
    chk("cmt.req_off", 32'(sb.mem_req_o), 32'd0);
    step();
    drain_all("cmt.drained");

    // Allocate 3, then commit + flush + allocate in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_in(); alloc(32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF); step();
    end
    idle_in(); alloc(32'h30C, 32'hB000_0003, 4'hF); sb.flush_i = 1'b1;
    sb.commit_valid_i = 1'b1; sb.commit_idx_i = 2'd0;
    #1 chk("flush.ready", 32'(sb.alloc_ready_o), 32'd0);
    step();
    idle_in();
    #1 chk("flush.count", 32'(sb.count_o), 32'd1);
    chk("flush.tail", 32'(sb.alloc_idx_o), 32'd1);
    w0 = dut_writes;
    step();
    drain_all("flush.drained");
    chk("flush.writes", 32'(dut_writes - w0), 32'd1);
    chk("flush.tail_after", 32'(sb.alloc_idx_o), 32'd1);

    // Stall in REQ with flush toggling: outputs hold, one write on grant
    idle_in(); alloc(32'h400, 32'hCAFE_0400, 4'h6); step();
    idle_in(); alloc(32'h404, 32'hCAFE_0404, 4'hF); commit_next(); step();
    w0 = dut_writes;
    for (int i = 0; i < 5; i++) begin
      idle_in(); sb.flush_i = i[0];
      #1 chk("stall.req", 32'(sb.mem_req_o), 32'd1);
      chk("stall.addr", sb.mem_addr_o, 32'h400);
      chk("stall.data", sb.mem_data_o, 32'hCAFE_0400);
      chk("stall.be", 32'(sb.mem_be_o), 32'h6);
      step();
    end
    idle_in(); sb.mem_gnt_i = 1'b1; step();
    idle_in();
    #1 chk("stall.writes", 32'(dut_writes - w0), 32'd1);
    step();
    drain_all("stall.drained");

    // Load hazard: visible the cycle after allocation, byte-lane sensitive
    idle_in(); alloc(32'h200, 32'h0000_BEEF, 4'b0011); sb.ld_addr_i = 32'h200; sb.ld_be_i = 4'b0001;
    #1 chk("hz.same_cycle", 32'(sb.ld_hazard_o), 32'd0);
    step();
    idle_in(); sb.ld_addr_i = 32'h202; sb.ld_be_i = 4'b1100;
    #1 chk("hz.no_overlap", 32'(sb.ld_hazard_o), 32'd0);
    step();
    idle_in(); sb.ld_addr_i = 32'h200; sb.ld_be_i = 4'b0001;
    #1 chk("hz.overlap", 32'(sb.ld_hazard_o), 32'd1);
    step();
    idle_in(); sb.flush_i = 1'b1; step();
    idle_in();
    #1 chk("hz.flushed", 32'(sb.empty_o), 32'd1);
    step();

    // Random: 20 stores, random grants, occasional flush, one bad commit index
    issued = 0;
    for (int cyc = 0; cyc < 3000 && !(issued == 20 && q.size() == 0); cyc++) begin
      idle_in();
      if (issued < 20 && $urandom_range(0, 1) == 1)
        alloc(32'h500 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
              $urandom, 4'($urandom_range(1, 15)));
      sb.flush_i = ($urandom_range(0, 19) == 0);
      if (ncmt < q.size() && $urandom_range(0, 1) == 1) begin
        commit_next();
        if (!bad_done && issued > 6) begin
          sb.commit_idx_i = IW'((head_idx + ncmt + 1) % SB);
          bad_done = 1'b1;
        end
      end
      sb.mem_gnt_i = ($urandom_range(0, 1) == 1);
      sb.ld_addr_i = 32'h500 + 32'(4 * $urandom_range(0, 7));
      sb.ld_be_i   = 4'($urandom_range(1, 15));
      if (sb.alloc_valid_i && q.size() < SB && !sb.flush_i) issued++;
      step();
    end
    idle_in();
    #1 chk("rand.finished", 32'(issued == 20 && q.size() == 0), 32'd1);
    chk("rand.empty", 32'(sb.empty_o), 32'd1);
    step();

    // Reset asserted mid-drain drops the request without a clock edge
    idle_in(); alloc(32'h600, 32'hD00D_0600, 4'hF); step();
    idle_in(); commit_next(); step();
    idle_in();
    #1 chk("rst.req_before", 32'(sb.mem_req_o), 32'd1);
    rst_n = 1'b0;
    #1 chk("rst.req_async", 32'(sb.mem_req_o), 32'd0);
    chk("rst.count_async", 32'(sb.count_o), 32'd0);
    chk("rst.addr_async", sb.mem_addr_o, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    chk("writes.total", 32'(dut_writes), 32'(writes));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
